// File: rtl/regfile_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : regfile_pkg
//  Description : Shared constants and types for the 32 x 64-bit register file.
//  Revision    : 1.0  initial release
// ============================================================================
package regfile_pkg;

    localparam int REG_WIDTH  = 64;
    localparam int REG_ADDR_W = 5;
    localparam int REG_COUNT  = 32;

    typedef logic [REG_ADDR_W-1:0] reg_addr_t;
    typedef logic [REG_WIDTH-1:0]  reg_data_t;

    // XZR: architectural zero register, never stored
    localparam reg_addr_t ZERO_REG = 5'd31;

endpackage : regfile_pkg
`default_nettype wire

// File: rtl/regfile_decoder.sv
`default_nettype none
// ============================================================================
//  Module      : regfile_decoder
//  Description : Write-address decode. Enabled 5-to-32 one-hot decode with
//                the top output (XZR) held low so it can never be written.
//  Revision    : 1.0  initial release
// ============================================================================
module regfile_decoder
    import regfile_pkg::*;
#(
    parameter int NREGS  = REG_COUNT,
    parameter int ADDR_W = REG_ADDR_W
) (
    input  logic              en_i,
    input  logic [ADDR_W-1:0] addr_i,
    output logic [NREGS-1:0]  we_o
);

    // One-hot decode; address is only looked at when enabled so an
    // undriven address with en_i low produces no enable at all.
    always_comb begin
        we_o = '0;
        if (en_i) begin
            we_o[addr_i] = 1'b1;
        end
        we_o[NREGS-1] = 1'b0;
    end

endmodule : regfile_decoder
`default_nettype wire

// File: rtl/regfile.sv
`default_nettype none
// ============================================================================
//  Module      : regfile
//  Description : 32 x 64-bit ARM register file. Two combinational read
//                ports, one synchronous write port, XZR hardwired to zero,
//                write-to-read bypass so ID sees the value WB is writing.
//  Revision    : 1.0  initial release
// ============================================================================
module regfile
    import regfile_pkg::*;
#(
    parameter int WIDTH  = REG_WIDTH,
    parameter int NREGS  = REG_COUNT,
    parameter int ADDR_W = REG_ADDR_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              RegWrite,
    input  logic [ADDR_W-1:0] WriteRegister,
    input  logic [WIDTH-1:0]  WriteData,
    input  logic [ADDR_W-1:0] ReadRegister1,
    input  logic [ADDR_W-1:0] ReadRegister2,
    output logic [WIDTH-1:0]  ReadData1,
    output logic [WIDTH-1:0]  ReadData2
);

    localparam logic [ADDR_W-1:0] ZERO_IDX = ADDR_W'(NREGS - 1);

    logic [NREGS-1:0] we_w;
    logic [WIDTH-1:0] entries_w [NREGS];
    logic             wr_valid_w;
    logic             byp1_w;
    logic             byp2_w;

    regfile_decoder #(
        .NREGS  (NREGS),
        .ADDR_W (ADDR_W)
    ) u_decoder (
        .en_i   (RegWrite),
        .addr_i (WriteRegister),
        .we_o   (we_w)
    );

    // Storage for X0..X30; XZR has no flops
    for (genvar g = 0; g < NREGS - 1; g++) begin : g_entry
        logic [WIDTH-1:0] entry_q;
        logic [WIDTH-1:0] entry_d;

        assign entry_d = we_w[g] ? WriteData : entry_q;

        // Enable register, cleared asynchronously by reset
        always_ff @(posedge clk or negedge reset) begin
            if (!reset) begin
                entry_q <= '0;
            end else begin
                entry_q <= entry_d;
            end
        end

        assign entries_w[g] = entry_q;
    end

    // Mux input for XZR is a constant zero
    assign entries_w[NREGS-1] = '0;

    // A write that will land this cycle, visible to readers via the bypass
    assign wr_valid_w = RegWrite && reset && (WriteRegister != ZERO_IDX);
    assign byp1_w     = wr_valid_w && (ReadRegister1 == WriteRegister);
    assign byp2_w     = wr_valid_w && (ReadRegister2 == WriteRegister);

    // Read ports: 32:1 mux then bypass select; forced to zero during reset
    always_comb begin
        ReadData1 = '0;
        ReadData2 = '0;
        if (reset) begin
            ReadData1 = byp1_w ? WriteData : entries_w[ReadRegister1];
            ReadData2 = byp2_w ? WriteData : entries_w[ReadRegister2];
        end
    end

endmodule : regfile
`default_nettype wire

// File: tb/tb_regfile.sv
`default_nettype none
// ============================================================================
//  Module      : tb_regfile
//  Description : Directed self-checking bench for regfile.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_regfile;

    logic        clk;
    logic        reset;
    logic        RegWrite;
    logic [4:0]  WriteRegister;
    logic [63:0] WriteData;
    logic [4:0]  ReadRegister1;
    logic [4:0]  ReadRegister2;
    logic [63:0] ReadData1;
    logic [63:0] ReadData2;

    int checks_q;
    int errors_q;

    regfile dut (
        .clk           (clk),
        .reset         (reset),
        .RegWrite      (RegWrite),
        .WriteRegister (WriteRegister),
        .WriteData     (WriteData),
        .ReadRegister1 (ReadRegister1),
        .ReadRegister2 (ReadRegister2),
        .ReadData1     (ReadData1),
        .ReadData2     (ReadData2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        checks_q++;
        if (act !== exp) begin
            errors_q++;
            $display("FAIL %s got %h expected %h", tag, act, exp);
        end
    endtask

    // Single write: drive at negedge, commit on posedge, drop enable after
    task automatic wr(input logic [4:0] a, input logic [63:0] d);
        @(negedge clk);
        RegWrite      = 1'b1;
        WriteRegister = a;
        WriteData     = d;
        @(posedge clk);
        #1;
        RegWrite      = 1'b0;
    endtask

    task automatic rd(input logic [4:0] a1, input logic [4:0] a2);
        ReadRegister1 = a1;
        ReadRegister2 = a2;
        #1;
    endtask

    initial begin
        checks_q      = 0;
        errors_q      = 0;
        reset         = 1'b0;
        RegWrite      = 1'b1;
        WriteRegister = 5'd5;
        WriteData     = 64'h1234;
        ReadRegister1 = 5'd5;
        ReadRegister2 = 5'd0;

        // Reset: bypass blocked, reads zero, writes blocked across an edge
        #2;
        check("rst_byp", ReadData1, 64'h0);
        @(posedge clk); #1;
        check("rst_edge", ReadData1, 64'h0);
        check("rst_x0", ReadData2, 64'h0);
        @(negedge clk);
        RegWrite = 1'b0;
        reset    = 1'b1;

        // Write X5, then assert reset between edges
        wr(5'd5, 64'h1234);
        rd(5'd5, 5'd0);
        check("x5_wr", ReadData1, 64'h1234);
        reset = 1'b0;
        #1;
        check("x5_async_clr", ReadData1, 64'h0);
        RegWrite      = 1'b1;
        WriteRegister = 5'd5;
        WriteData     = 64'h9999;
        @(posedge clk); #1;
        check("x5_rst_blk", ReadData1, 64'h0);
        // Release between edges with write pending: lands on next edge
        @(negedge clk);
        reset     = 1'b1;
        WriteData = 64'h77;
        @(posedge clk); #1;
        RegWrite = 1'b0;
        #1;
        check("x5_post_rst", ReadData1, 64'h77);

        // Write/read X1, X2
        wr(5'd1, 64'hAAAAAAAAAAAAAAAA);
        wr(5'd2, 64'hBBBBBBBBBBBBBBBB);
        rd(5'd1, 5'd2);
        check("x1_rd", ReadData1, 64'hAAAAAAAAAAAAAAAA);
        check("x2_rd", ReadData2, 64'hBBBBBBBBBBBBBBBB);
        @(negedge clk);
        WriteRegister = 5'd1;
        WriteData     = 64'hFFFFFFFFFFFFFFFF;
        @(posedge clk); #1;
        check("x1_hold", ReadData1, 64'hAAAAAAAAAAAAAAAA);
        check("x2_hold", ReadData2, 64'hBBBBBBBBBBBBBBBB);

        // Zero register
        @(negedge clk);
        RegWrite      = 1'b1;
        WriteRegister = 5'd31;
        WriteData     = 64'hDEADBEEF;
        rd(5'd31, 5'd5);
        check("xzr_pre", ReadData1, 64'h0);
        @(posedge clk); #1;
        check("xzr_post", ReadData1, 64'h0);
        check("xzr_x5", ReadData2, 64'h77);
        RegWrite = 1'b0;
        rd(5'd1, 5'd2);
        check("xzr_x1", ReadData1, 64'hAAAAAAAAAAAAAAAA);
        check("xzr_x2", ReadData2, 64'hBBBBBBBBBBBBBBBB);

        // Bypass on both ports
        wr(5'd3, 64'h1);
        @(negedge clk);
        RegWrite      = 1'b1;
        WriteRegister = 5'd3;
        WriteData     = 64'h55;
        rd(5'd3, 5'd3);
        check("byp_p1", ReadData1, 64'h55);
        check("byp_p2", ReadData2, 64'h55);
        @(posedge clk); #1;
        RegWrite = 1'b0;
        #1;
        check("byp_st1", ReadData1, 64'h55);
        check("byp_st2", ReadData2, 64'h55);

        // Independent ports
        wr(5'd4, 64'h7);
        wr(5'd6, 64'h9);
        @(negedge clk);
        RegWrite      = 1'b1;
        WriteRegister = 5'd6;
        WriteData     = 64'hC;
        rd(5'd4, 5'd6);
        check("ind_p1", ReadData1, 64'h7);
        check("ind_p2", ReadData2, 64'hC);
        @(posedge clk); #1;
        RegWrite = 1'b0;

        // Back-to-back writes to one register
        wr(5'd7, 64'h1);
        wr(5'd7, 64'h2);
        rd(5'd7, 5'd7);
        check("x7_last", ReadData1, 64'h2);

        // Unknown write address with enable low
        @(negedge clk);
        RegWrite      = 1'b0;
        WriteRegister = 5'bxxxxx;
        WriteData     = 64'h0BAD;
        @(posedge clk); #1;
        rd(5'd1, 5'd7);
        check("x_addr_x1", ReadData1, 64'hAAAAAAAAAAAAAAAA);
        check("x_addr_x7", ReadData2, 64'h2);

        // Sweep all entries
        for (int i = 0; i < 31; i++) begin
            wr(5'(i), 64'(i) * 64'h0101010101010101);
        end
        for (int i = 0; i < 31; i++) begin
            rd(5'(i), 5'(30 - i));
            check($sformatf("sw_p1_%0d", i), ReadData1, 64'(i) * 64'h0101010101010101);
            check($sformatf("sw_p2_%0d", i), ReadData2, 64'(30 - i) * 64'h0101010101010101);
        end
        rd(5'd31, 5'd31);
        check("sw_xzr1", ReadData1, 64'h0);
        check("sw_xzr2", ReadData2, 64'h0);

        $display("CHECKS %0d ERRORS %0d", checks_q, errors_q);
        $finish;
    end

endmodule : tb_regfile
`default_nettype wire
